// File: rtl/pae32_pkg.sv
// Shared widths, fault cause encodings and FSM state type for the PAE32
// address translation stage.
package pae32_pkg;

  localparam int VA_W = 24;
  localparam int PA_W = 32;

  typedef enum logic [1:0] {
    PF_NONE  = 2'b00,
    PF_IMISS = 2'b01,
    PF_DRD   = 2'b10,
    PF_DWR   = 2'b11
  } pf_cause_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FAULT = 1'b1
  } xlat_state_e;

endpackage

// File: rtl/pae32_xlat_port.sv
// Combinational translation for one port: picks flat, supervisor huge-page
// or user single-tag mapping from the mode bits and composes the PA.
module pae32_xlat_port
  import pae32_pkg::*;
(
  input  logic            mmu_enable,
  input  logic            supervisor_mode,
  input  logic [10:0]     hugepage_ptr,
  input  logic [7:0]      pte_h8,
  input  logic [15:0]     pae_h16,
  input  logic [VA_W-1:0] va,
  output logic            hit,
  output logic [PA_W-1:0] pa
);

  always_comb begin
    hit = 1'b1;
    pa  = {8'h00, va};
    if (mmu_enable) begin
      if (supervisor_mode) begin
        // Upper half of the VA space maps onto the single 2 MiB huge page.
        if (va[23]) begin
          pa = {hugepage_ptr, va[20:0]};
        end
      end else begin
        hit = (va[23:16] == pte_h8);
        pa  = {pae_h16, va[15:0]};
      end
    end
  end

endmodule

// File: rtl/pae32_xlat_unit.sv
// PAE32 translation stage: two translation ports, registered responses and an
// IDLE/FAULT handshake FSM. Optional fault counter: PAE32_XLAT_FAULT_CNT_EN.
module pae32_xlat_unit
  import pae32_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            mmu_enable,
  input  logic            supervisor_mode,
  input  logic [10:0]     hugepage_ptr,
  input  logic [7:0]      ipte_h8,
  input  logic [7:0]      dpte_h8,
  input  logic [15:0]     ipae_h16,
  input  logic [15:0]     dpae_h16,
  input  logic            i_req_valid,
  output logic            i_req_ready,
  input  logic [VA_W-1:0] i_va,
  output logic            i_rsp_valid,
  output logic [PA_W-1:0] i_pa,
  input  logic            d_req_valid,
  output logic            d_req_ready,
  input  logic [VA_W-1:0] d_va,
  input  logic            d_we,
  output logic            d_rsp_valid,
  output logic [PA_W-1:0] d_pa,
  output logic            d_rsp_we,
  output logic            pf_req,
  input  logic            pf_ack,
  output logic [1:0]      pf_cause,
  output logic [VA_W-1:0] pf_va,
  output logic [7:0]      fault_cnt
);

  // Handshake: a request is accepted on a rising clk edge where
  // req_valid & req_ready; the response follows exactly one cycle later with
  // no backpressure. pf_req stays high until pf_ack is sampled high.

  xlat_state_e     state_q, state_d;
  pf_cause_e       pf_cause_q, pf_cause_d;
  logic [VA_W-1:0] pf_va_q, pf_va_d;
  logic            i_rsp_valid_q, i_rsp_valid_d;
  logic [PA_W-1:0] i_pa_q, i_pa_d;
  logic            d_rsp_valid_q, d_rsp_valid_d;
  logic [PA_W-1:0] d_pa_q, d_pa_d;
  logic            d_rsp_we_q, d_rsp_we_d;

  logic            i_hit, d_hit;
  logic [PA_W-1:0] i_pa_x, d_pa_x;
  logic            i_acc, d_acc, i_miss, d_miss, ready;

  pae32_xlat_port u_iport (
    .mmu_enable      (mmu_enable),
    .supervisor_mode (supervisor_mode),
    .hugepage_ptr    (hugepage_ptr),
    .pte_h8          (ipte_h8),
    .pae_h16         (ipae_h16),
    .va              (i_va),
    .hit             (i_hit),
    .pa              (i_pa_x)
  );

  pae32_xlat_port u_dport (
    .mmu_enable      (mmu_enable),
    .supervisor_mode (supervisor_mode),
    .hugepage_ptr    (hugepage_ptr),
    .pte_h8          (dpte_h8),
    .pae_h16         (dpae_h16),
    .va              (d_va),
    .hit             (d_hit),
    .pa              (d_pa_x)
  );

  // Ready is forced low while rst is held so nothing is accepted in reset.
  assign ready  = ~rst & (state_q == ST_IDLE);
  assign i_acc  = i_req_valid & ready;
  assign d_acc  = d_req_valid & ready;
  assign i_miss = i_acc & ~i_hit;
  assign d_miss = d_acc & ~d_hit;

  always_comb begin
    state_d    = state_q;
    pf_cause_d = pf_cause_q;
    pf_va_d    = pf_va_q;
    case (state_q)
      ST_IDLE: begin
        // Data miss wins; a simultaneous instruction miss is simply refetched.
        if (d_miss) begin
          state_d    = ST_FAULT;
          pf_cause_d = d_we ? PF_DWR : PF_DRD;
          pf_va_d    = d_va;
        end else if (i_miss) begin
          state_d    = ST_FAULT;
          pf_cause_d = PF_IMISS;
          pf_va_d    = i_va;
        end
      end
      ST_FAULT: begin
        if (pf_ack) begin
          state_d    = ST_IDLE;
          pf_cause_d = PF_NONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    i_rsp_valid_d = i_acc & i_hit;
    i_pa_d        = (i_acc & i_hit) ? i_pa_x : i_pa_q;
    d_rsp_valid_d = d_acc & d_hit;
    d_pa_d        = (d_acc & d_hit) ? d_pa_x : d_pa_q;
    d_rsp_we_d    = d_acc & d_hit & d_we;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pf_cause_q    <= PF_NONE;
      pf_va_q       <= '0;
      i_rsp_valid_q <= 1'b0;
      i_pa_q        <= '0;
      d_rsp_valid_q <= 1'b0;
      d_pa_q        <= '0;
      d_rsp_we_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pf_cause_q    <= pf_cause_d;
      pf_va_q       <= pf_va_d;
      i_rsp_valid_q <= i_rsp_valid_d;
      i_pa_q        <= i_pa_d;
      d_rsp_valid_q <= d_rsp_valid_d;
      d_pa_q        <= d_pa_d;
      d_rsp_we_q    <= d_rsp_we_d;
    end
  end

`ifdef PAE32_XLAT_FAULT_CNT_EN
  logic       fault_enter;
  logic [7:0] fault_cnt_q, fault_cnt_d;

  assign fault_enter = (state_q == ST_IDLE) & (state_d == ST_FAULT);

  always_comb begin
    fault_cnt_d = fault_cnt_q;
    if (fault_enter && (fault_cnt_q != 8'hFF)) begin
      fault_cnt_d = fault_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_cnt_q <= 8'h00;
    end else begin
      fault_cnt_q <= fault_cnt_d;
    end
  end

  assign fault_cnt = fault_cnt_q;
`else
  assign fault_cnt = 8'h00;
`endif

  assign i_req_ready = ready;
  assign d_req_ready = ready;
  assign i_rsp_valid = i_rsp_valid_q;
  assign i_pa        = i_pa_q;
  assign d_rsp_valid = d_rsp_valid_q;
  assign d_pa        = d_pa_q;
  assign d_rsp_we    = d_rsp_we_q;
  assign pf_req      = (state_q == ST_FAULT);
  assign pf_cause    = pf_cause_q;
  assign pf_va       = pf_va_q;

endmodule

// File: tb/tb_pae32_xlat_unit.sv
// Bench for pae32_xlat_unit: vector table, response scoreboard, and
// hand-written fault / reset sequences.
module tb_pae32_xlat_unit;

  logic        clk;
  logic        rst;
  logic        mmu_enable, supervisor_mode;
  logic [10:0] hugepage_ptr;
  logic [7:0]  ipte_h8, dpte_h8;
  logic [15:0] ipae_h16, dpae_h16;
  logic        i_req_valid, i_req_ready, i_rsp_valid;
  logic [23:0] i_va;
  logic [31:0] i_pa;
  logic        d_req_valid, d_req_ready, d_rsp_valid, d_we, d_rsp_we;
  logic [23:0] d_va;
  logic [31:0] d_pa;
  logic        pf_req, pf_ack;
  logic [1:0]  pf_cause;
  logic [23:0] pf_va;
  logic [7:0]  fault_cnt;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_cnt = 8'h00;

  // {we, pa} per expected response
  logic [32:0] i_exp_q[$];
  logic [32:0] d_exp_q[$];

  typedef struct {
    logic        port_d;
    logic        mmu;
    logic        sup;
    logic [10:0] hp;
    logic [7:0]  tag;
    logic [15:0] pae;
    logic [23:0] va;
    logic        we;
    logic [31:0] exp_pa;
  } vec_t;

  vec_t tbl[8];

  pae32_xlat_unit dut (
    .clk             (clk),
    .rst             (rst),
    .mmu_enable      (mmu_enable),
    .supervisor_mode (supervisor_mode),
    .hugepage_ptr    (hugepage_ptr),
    .ipte_h8         (ipte_h8),
    .dpte_h8         (dpte_h8),
    .ipae_h16        (ipae_h16),
    .dpae_h16        (dpae_h16),
    .i_req_valid     (i_req_valid),
    .i_req_ready     (i_req_ready),
    .i_va            (i_va),
    .i_rsp_valid     (i_rsp_valid),
    .i_pa            (i_pa),
    .d_req_valid     (d_req_valid),
    .d_req_ready     (d_req_ready),
    .d_va            (d_va),
    .d_we            (d_we),
    .d_rsp_valid     (d_rsp_valid),
    .d_pa            (d_pa),
    .d_rsp_we        (d_rsp_we),
    .pf_req          (pf_req),
    .pf_ack          (pf_ack),
    .pf_cause        (pf_cause),
    .pf_va           (pf_va),
    .fault_cnt       (fault_cnt)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic note_fault();
`ifdef PAE32_XLAT_FAULT_CNT_EN
    if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
`endif
  endtask

  function automatic logic [31:0] model_pa(input logic mmu, input logic sup,
                                           input logic [10:0] hp, input logic [15:0] pae,
                                           input logic [23:0] va);
    if (!mmu) return {8'h00, va};
    if (sup) return va[23] ? {hp, va[20:0]} : {8'h00, va};
    return {pae, va[15:0]};
  endfunction

  task automatic check_fault(input string name, input logic [1:0] cause, input logic [23:0] va);
    check({name, "_pf_req"}, pf_req, 1);
    check({name, "_pf_cause"}, pf_cause, cause);
    check({name, "_pf_va"}, pf_va, va);
    check({name, "_i_ready"}, i_req_ready, 0);
    check({name, "_d_ready"}, d_req_ready, 0);
  endtask

  task automatic ack_fault(input string name);
    pf_ack = 1'b1;
    step();
    pf_ack = 1'b0;
    check({name, "_pf_req_drop"}, pf_req, 0);
    check({name, "_ready_back"}, i_req_ready & d_req_ready, 1);
  endtask

  task automatic idle_inputs();
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
    d_we        = 1'b0;
    pf_ack      = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (i_rsp_valid) begin
        if (i_exp_q.size() == 0) begin
          check("i_rsp_unexpected", i_rsp_valid, 0);
        end else begin
          logic [32:0] e;
          e = i_exp_q.pop_front();
          check("i_pa", i_pa, e[31:0]);
        end
      end else if (i_exp_q.size() != 0) begin
        check("i_rsp_missing", i_rsp_valid, 1);
        void'(i_exp_q.pop_front());
      end
      if (d_rsp_valid) begin
        if (d_exp_q.size() == 0) begin
          check("d_rsp_unexpected", d_rsp_valid, 0);
        end else begin
          logic [32:0] e;
          e = d_exp_q.pop_front();
          check("d_pa", d_pa, e[31:0]);
          check("d_rsp_we", d_rsp_we, e[32]);
        end
      end else if (d_exp_q.size() != 0) begin
        check("d_rsp_missing", d_rsp_valid, 1);
        void'(d_exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    mmu_enable = 1'b0; supervisor_mode = 1'b0; hugepage_ptr = '0;
    ipte_h8 = '0; dpte_h8 = '0; ipae_h16 = '0; dpae_h16 = '0;
    i_va = '0; d_va = '0;
    idle_inputs();

    tbl[0] = '{1'b0, 1'b0, 1'b0, 11'h000, 8'h00, 16'h0000, 24'h12_3456, 1'b0, 32'h0012_3456};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 11'h5A3, 8'h00, 16'h0000, 24'h81_2345, 1'b0, 32'hB461_2345};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 11'h5A3, 8'h00, 16'h0000, 24'h01_2345, 1'b0, 32'h0001_2345};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 11'h000, 8'h40, 16'hBEEF, 24'h40_0010, 1'b1, 32'hBEEF_0010};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 11'h000, 8'h7F, 16'h1234, 24'h7F_ABCD, 1'b0, 32'h1234_ABCD};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 11'h7FF, 8'h00, 16'h0000, 24'hFF_FFFF, 1'b0, 32'hFFFF_FFFF};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 11'h5A3, 8'h00, 16'h0000, 24'h81_2345, 1'b1, 32'h0081_2345};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 11'h000, 8'h00, 16'h0001, 24'h00_FFFF, 1'b0, 32'h0001_FFFF};

    // Reset values
    #2;
    check("rst_i_ready", i_req_ready, 0);
    check("rst_d_ready", d_req_ready, 0);
    check("rst_pf_req", pf_req, 0);
    check("rst_pf_cause", pf_cause, 0);
    check("rst_pf_va", pf_va, 0);
    check("rst_fault_cnt", fault_cnt, 0);
    check("rst_rsp_valid", {i_rsp_valid, d_rsp_valid, d_rsp_we}, 0);
    check("rst_i_pa", i_pa, 0);
    check("rst_d_pa", d_pa, 0);
    step();
    step();
    rst = 1'b0;
    #2;
    check("post_rst_ready", i_req_ready & d_req_ready, 1);
    step();

    // Table vectors, issued back to back
    for (int k = 0; k < 8; k++) begin
      mmu_enable      = tbl[k].mmu;
      supervisor_mode = tbl[k].sup;
      hugepage_ptr    = tbl[k].hp;
      ipte_h8 = tbl[k].tag; dpte_h8 = tbl[k].tag;
      ipae_h16 = tbl[k].pae; dpae_h16 = tbl[k].pae;
      i_req_valid = ~tbl[k].port_d;
      d_req_valid = tbl[k].port_d;
      i_va = tbl[k].va; d_va = tbl[k].va; d_we = tbl[k].we;
      @(posedge clk);
      if (tbl[k].port_d) d_exp_q.push_back({tbl[k].we, tbl[k].exp_pa});
      else               i_exp_q.push_back({1'b0, tbl[k].exp_pa});
      #1;
    end
    idle_inputs();
    step();

    // User data write miss, held fault, then ack
    mmu_enable = 1'b1; supervisor_mode = 1'b0; dpte_h8 = 8'h40;
    d_va = 24'h41_0000; d_we = 1'b1; d_req_valid = 1'b1;
    step();
    idle_inputs();
    note_fault();
    check_fault("dwr", 2'b11, 24'h41_0000);
    check("dwr_cnt", fault_cnt, exp_cnt);
    for (int k = 0; k < 5; k++) begin
      step();
      check_fault("dwr_hold", 2'b11, 24'h41_0000);
    end
    ack_fault("dwr");

    // Dual miss: data read fault wins, no instruction response
    ipte_h8 = 8'h10; dpte_h8 = 8'h20;
    i_va = 24'h11_0000; d_va = 24'h21_0000; d_we = 1'b0;
    i_req_valid = 1'b1; d_req_valid = 1'b1;
    step();
    idle_inputs();
    note_fault();
    check_fault("dual", 2'b10, 24'h21_0000);
    check("dual_cnt", fault_cnt, exp_cnt);
    ack_fault("dual");

    // Instruction miss with simultaneous data hit
    ipte_h8 = 8'h10; dpte_h8 = 8'h20; dpae_h16 = 16'hCAFE;
    i_va = 24'h33_0000; d_va = 24'h20_1234; d_we = 1'b1;
    i_req_valid = 1'b1; d_req_valid = 1'b1;
    @(posedge clk);
    d_exp_q.push_back({1'b1, 32'hCAFE_1234});
    #1;
    idle_inputs();
    note_fault();
    check_fault("imiss", 2'b01, 24'h33_0000);
    check("imiss_cnt", fault_cnt, exp_cnt);
    ack_fault("imiss");

    // pf_ack while idle has no effect
    mmu_enable = 1'b0; i_va = 24'hAB_CDEF; i_req_valid = 1'b1; pf_ack = 1'b1;
    @(posedge clk);
    i_exp_q.push_back({1'b0, 32'h00AB_CDEF});
    #1;
    idle_inputs();
    check("idle_ack_pf_req", pf_req, 0);
    check("idle_ack_ready", i_req_ready, 1);
    step();

    // Randomised hits on both ports
    for (int k = 0; k < 40; k++) begin
      logic [31:0] ip, dp;
      mmu_enable      = 1'($urandom_range(0, 1));
      supervisor_mode = 1'($urandom_range(0, 1));
      hugepage_ptr    = 11'($urandom_range(0, 2047));
      ipae_h16 = 16'($urandom_range(0, 65535));
      dpae_h16 = 16'($urandom_range(0, 65535));
      i_va = 24'($urandom_range(0, 24'hFF_FFFF));
      d_va = 24'($urandom_range(0, 24'hFF_FFFF));
      ipte_h8 = i_va[23:16]; dpte_h8 = d_va[23:16];
      d_we = 1'($urandom_range(0, 1));
      i_req_valid = 1'($urandom_range(0, 1));
      d_req_valid = 1'($urandom_range(0, 1));
      ip = model_pa(mmu_enable, supervisor_mode, hugepage_ptr, ipae_h16, i_va);
      dp = model_pa(mmu_enable, supervisor_mode, hugepage_ptr, dpae_h16, d_va);
      @(posedge clk);
      if (i_req_valid) i_exp_q.push_back({1'b0, ip});
      if (d_req_valid) d_exp_q.push_back({d_we, dp});
      #1;
    end
    idle_inputs();
    step();

    // Many instruction faults, each acked in the first fault cycle
    mmu_enable = 1'b1; supervisor_mode = 1'b0; ipte_h8 = 8'h01;
    for (int k = 0; k < 260; k++) begin
      i_va = 24'h02_0000 + 24'(k); i_req_valid = 1'b1;
      step();
      i_req_valid = 1'b0;
      note_fault();
      pf_ack = 1'b1;
      step();
      pf_ack = 1'b0;
    end
    check("sat_cnt", fault_cnt, exp_cnt);
    check("sat_ready", i_req_ready, 1);

    // Reset in the cycle after an accept suppresses the response
    mmu_enable = 1'b0; i_va = 24'h00_0042; i_req_valid = 1'b1;
    @(posedge clk);
    #1;
    i_req_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_sup_rsp", i_rsp_valid, 0);
    step();
    rst = 1'b0;
    exp_cnt = 8'h00;
    step();

    // Reset in the middle of a fault
    mmu_enable = 1'b1; supervisor_mode = 1'b0; dpte_h8 = 8'h55;
    d_va = 24'h66_0000; d_we = 1'b0; d_req_valid = 1'b1;
    step();
    idle_inputs();
    note_fault();
    check_fault("prerst", 2'b10, 24'h66_0000);
    rst = 1'b1;
    #1;
    check("midrst_pf_req", pf_req, 0);
    check("midrst_ready", i_req_ready | d_req_ready, 0);
    check("midrst_cause", pf_cause, 0);
    step();
    rst = 1'b0;
    exp_cnt = 8'h00;
    #2;
    check("postrst_ready", i_req_ready & d_req_ready, 1);
    check("postrst_cnt", fault_cnt, exp_cnt);
    mmu_enable = 1'b0; d_va = 24'h00_0777; d_we = 1'b1; d_req_valid = 1'b1;
    @(posedge clk);
    d_exp_q.push_back({1'b1, 32'h0000_0777});
    #1;
    idle_inputs();
    step();
    step();

    check("i_queue_drained", i_exp_q.size(), 0);
    check("d_queue_drained", d_exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pae32_xlat_unit.md
# pae32_xlat_unit

Address translation stage directly downstream of the PAE32 MMU control-register block. It consumes that block's mode bits, huge-page pointer and single-entry instruction/data page tags. It translates 24-bit instruction and data virtual addresses into 32-bit physical addresses with a one-cycle registered pipeline. On a tag miss it raises a held page-fault request to the exception logic and stalls both ports until the fault is acknowledged.

## Interface
- No parameters; widths fixed (VA 24, PA 32).
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- mmu_enable, supervisor_mode  in  1 each  mode bits from control registers
- hugepage_ptr  in  11  PA[31:21] for supervisor huge page
- ipte_h8 / dpte_h8  in  8  instr/data VA[23:16] tag
- ipae_h16 / dpae_h16  in  16  instr/data PA[31:16]
- i_req_valid  in  1 / i_req_ready  out  1 / i_va  in  24  instruction request
- i_rsp_valid  out  1 / i_pa  out  32  instruction result
- d_req_valid  in  1 / d_req_ready  out  1 / d_va  in  24 / d_we  in  1  data request
- d_rsp_valid  out  1 / d_pa  out  32 / d_rsp_we  out  1  data result
- pf_req  out  1 / pf_ack  in  1  fault handshake
- pf_cause  out  2  01 instr miss, 10 data read miss, 11 data write miss
- pf_va  out  24  faulting VA
- fault_cnt  out  8  saturating fault count (see Configuration)

## Operation
- Translation, selected per request by the mode bits sampled in the accept cycle:
  - mmu_enable=0 (flat mode): PA = {8'h00, VA}, never faults.
  - mmu_enable=1, supervisor_mode=1: VA[23]=1 gives PA = {hugepage_ptr, VA[20:0]}; VA[23]=0 gives flat; never faults.
  - mmu_enable=1, supervisor_mode=0 (user): VA[23:16]==tag gives PA = {pae_h16, VA[15:0]}. Any mismatch is a miss.
- FSM states: IDLE, FAULT.
  - IDLE: both readys = 1.
  - A miss on an accepted request moves to FAULT. It latches pf_cause and pf_va, and the missing port produces no response.
  - FAULT: readys = 0, pf_req = 1. pf_cause and pf_va are held stable.
  - The FSM returns to IDLE on the cycle pf_ack is sampled high.
- Simultaneous events:
  - Misses on both ports in the same cycle: the data fault is reported and the instruction miss is discarded (the core refetches).
  - A hit on one port in the same cycle as a miss on the other completes normally.
  - pf_ack sampled in IDLE is ignored.
- Control-register changes take effect on the next accepted request. An in-flight response is not altered.

## Timing
- Accept = req_valid & req_ready. rsp_valid is asserted exactly 1 cycle after a hitting accept and held for 1 cycle. There is no response backpressure.
- Faulting accept: pf_req is asserted the next cycle. After pf_ack is sampled high, pf_req drops and ready returns the following cycle.
- Fault-to-ready minimum is 2 cycles (ack in first FAULT cycle).
- Reset values: i_req_ready = d_req_ready = 0 during rst and 1 in the first cycle after release. i_rsp_valid = d_rsp_valid = d_rsp_we = 0. i_pa = d_pa = 0, pf_req = 0, pf_cause = 0, pf_va = 0, fault_cnt = 0. State = IDLE.
- Reset during FAULT aborts the fault with no ack needed. Reset in the cycle after an accept suppresses the response.

## Configuration
- PAE32_XLAT_FAULT_CNT_EN defined: fault_cnt increments on each entry into FAULT, saturates at 8'hFF, and clears only on rst. A dropped simultaneous instruction miss is not counted.
- Undefined: fault_cnt is tied to 8'h00 and no counter flops are built.

## Structure
- Shared package pae32_pkg holds:
  - VA_W = 24, PA_W = 32.
  - Cause encodings PF_NONE/PF_IMISS/PF_DRD/PF_DWR.
  - The FSM state enum.
- Sub-module pae32_xlat_port, instantiated twice (instr, data): combinational mode-select, tag compare and PA compose, giving a hit flag and a PA. The top level holds the response registers, the FSM and the counter.

## Test plan
- Flat mode: mmu_enable=0, i_va=24'h12_3456. Next cycle i_rsp_valid=1 and i_pa=32'h0012_3456.
- Huge page: supervisor mode, hugepage_ptr=11'h5A3, d_va=24'h81_2345. d_pa=32'hB461_2345. With d_va=24'h01_2345, d_pa=32'h0001_2345.
- User hit: dpte_h8=8'h40, dpae_h16=16'hBEEF, d_va=24'h40_0010, d_we=1. d_pa=32'hBEEF_0010 and d_rsp_we=1.
- User data write miss: d_va=24'h41_0000, d_we=1.
  - Next cycle pf_req=1, pf_cause=11, pf_va=24'h41_0000 and both readys are 0.
  - Holding pf_ack=0 for 5 cycles keeps all outputs stable.
  - pf_ack=1 returns ready the cycle after.
- Dual miss: both ports miss in the same cycle. Expect pf_cause=10/11, no i_rsp_valid, and fault_cnt +1 (macro on).
- Reset mid-fault: assert rst while in FAULT. pf_req goes to 0 immediately, and ready=1 in the first cycle after release.
